multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RISC-V core. Sequences fetch, decode, execute, memory and writeback over several cycles per instruction, driving datapath mux selects and write enables. Produces the 2-bit `aluOp` consumed by the ALU decoder. Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RISC-V core: sequences each instruction
// over several cycles, drives datapath selects/enables and counts retirements.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        adrSrc,
    output logic        memWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic [1:0]  resultSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;
    logic        pc_we, ir_we, mem_we, reg_we, ill;

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        ill       = 1'b0;
        adrSrc    = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        case (state_q)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                ir_we     = memReady;
                pc_we     = memReady;
                if (memReady) state_d = DECODE;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d = FETCH;
                        ill     = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
                if (memReady) state_d = MEMWB;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                reg_we    = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                adrSrc = 1'b1;
                mem_we = 1'b1;
                if (memReady) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECUTER: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            BEQ: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                pc_we   = zero;
                retire  = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pc_we   = 1'b1;
                state_d = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write strobes are masked by reset so an abandoned instruction writes nothing.
    assign pcWrite  = pc_we  & ~reset;
    assign irWrite  = ir_we  & ~reset;
    assign memWrite = mem_we & ~reset;
    assign regWrite = reg_we & ~reset;
    assign illegal  = ill    & ~reset;

    assign retired_d = retire ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic        zero;
    logic        memReady;
    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, aluOp;
    logic [3:0]  state;
    logic [31:0] retired;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .memReady  (memReady),
        .pcWrite   (pcWrite),
        .adrSrc    (adrSrc),
        .memWrite  (memWrite),
        .irWrite   (irWrite),
        .regWrite  (regWrite),
        .resultSrc (resultSrc),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluOp     (aluOp),
        .illegal   (illegal),
        .state     (state),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle before looking at outputs.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        op       = 7'b0;
        zero     = 1'b0;
        memReady = 1'b1;
        cyc();
        check("rst_state", {28'b0, state}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_pcWrite_masked", {31'b0, pcWrite}, 32'd0);
        check("rst_irWrite_masked", {31'b0, irWrite}, 32'd0);
        reset = 1'b0;
        memReady = 1'b0;
        #1;
        // FETCH stall
        check("fetch_stall_ir", {31'b0, irWrite}, 32'd0);
        cyc();
        check("fetch_stall_state", {28'b0, state}, 32'd0);

        // R-type: 0,1,6,8,0
        memReady = 1'b1; op = 7'b0110011; #1;
        check("r_fetch_ir", {31'b0, irWrite}, 32'd1);
        check("r_fetch_pc", {31'b0, pcWrite}, 32'd1);
        check("r_fetch_srcB", {30'b0, aluSrcB}, 32'd2);
        check("r_fetch_res", {30'b0, resultSrc}, 32'd2);
        cyc();
        check("r_s1", {28'b0, state}, 32'd1);
        check("r_dec_srcA", {30'b0, aluSrcA}, 32'd1);
        check("r_dec_srcB", {30'b0, aluSrcB}, 32'd1);
        cyc();
        check("r_s6", {28'b0, state}, 32'd6);
        check("r_aluOp", {30'b0, aluOp}, 32'd2);
        check("r_s6_regw", {31'b0, regWrite}, 32'd0);
        cyc();
        check("r_s8", {28'b0, state}, 32'd8);
        check("r_s8_regw", {31'b0, regWrite}, 32'd1);
        cyc();
        check("r_s0", {28'b0, state}, 32'd0);
        check("r_retired", retired, 32'd1);

        // lw with two stall cycles in MEMREAD
        op = 7'b0000011;
        cyc();
        check("lw_s1", {28'b0, state}, 32'd1);
        cyc();
        check("lw_s2", {28'b0, state}, 32'd2);
        check("lw_s2_srcA", {30'b0, aluSrcA}, 32'd2);
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) memReady = 1'b1;
            #1;
            check("lw_s3", {28'b0, state}, 32'd3);
            check("lw_s3_adr", {31'b0, adrSrc}, 32'd1);
        end
        cyc();
        check("lw_s4", {28'b0, state}, 32'd4);
        check("lw_s4_regw", {31'b0, regWrite}, 32'd1);
        check("lw_s4_res", {30'b0, resultSrc}, 32'd1);
        cyc();
        check("lw_s0", {28'b0, state}, 32'd0);
        check("lw_retired", retired, 32'd2);

        // sw with one stall cycle
        op = 7'b0100011;
        cyc(); cyc();
        check("sw_s2", {28'b0, state}, 32'd2);
        memReady = 1'b0;
        cyc();
        check("sw_s5a", {28'b0, state}, 32'd5);
        check("sw_memw_a", {31'b0, memWrite}, 32'd1);
        check("sw_ret_hold", retired, 32'd2);
        cyc();
        memReady = 1'b1; #1;
        check("sw_s5b", {28'b0, state}, 32'd5);
        check("sw_memw_b", {31'b0, memWrite}, 32'd1);
        cyc();
        check("sw_s0", {28'b0, state}, 32'd0);
        check("sw_retired", retired, 32'd3);

        // beq taken then not taken
        op = 7'b1100011;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            cyc(); cyc();
            check("beq_s9", {28'b0, state}, 32'd9);
            check("beq_pcw", {31'b0, pcWrite}, {31'b0, z[0]});
            check("beq_aluOp", {30'b0, aluOp}, 32'd1);
            cyc();
            check("beq_s0", {28'b0, state}, 32'd0);
        end
        check("beq_retired", retired, 32'd5);

        // illegal opcode
        op = 7'b1111111;
        cyc();
        check("ill_s1", {28'b0, state}, 32'd1);
        check("ill_pulse", {31'b0, illegal}, 32'd1);
        cyc();
        check("ill_s0", {28'b0, state}, 32'd0);
        check("ill_clear", {31'b0, illegal}, 32'd0);
        check("ill_retired", retired, 32'd5);

        // jal: 0,1,10,8,0
        op = 7'b1101111;
        cyc(); cyc();
        check("jal_s10", {28'b0, state}, 32'd10);
        check("jal_pcw", {31'b0, pcWrite}, 32'd1);
        check("jal_srcA", {30'b0, aluSrcA}, 32'd1);
        check("jal_srcB", {30'b0, aluSrcB}, 32'd2);
        cyc();
        check("jal_s8", {28'b0, state}, 32'd8);
        cyc();
        check("jal_retired", retired, 32'd6);

        // I-type: 0,1,7,8,0
        op = 7'b0010011;
        cyc(); cyc();
        check("i_s7", {28'b0, state}, 32'd7);
        check("i_srcB", {30'b0, aluSrcB}, 32'd1);
        check("i_aluOp", {30'b0, aluOp}, 32'd2);
        cyc(); cyc();
        check("i_s0", {28'b0, state}, 32'd0);
        check("i_retired", retired, 32'd7);

        // reset during MEMWRITE
        op = 7'b0100011;
        cyc(); cyc();
        memReady = 1'b0;
        cyc();
        check("rsw_s5", {28'b0, state}, 32'd5);
        check("rsw_memw", {31'b0, memWrite}, 32'd1);
        reset = 1'b1; #1;
        check("rsw_memw_drop", {31'b0, memWrite}, 32'd0);
        cyc();
        check("rsw_s0", {28'b0, state}, 32'd0);
        check("rsw_retired", retired, 32'd0);
        reset = 1'b0;

        // counter wrap: preload all-ones while stalled in FETCH
        #1;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        cyc();
        check("wrap_preload", retired, 32'hFFFF_FFFF);
        memReady = 1'b1; op = 7'b0110011;
        for (int i = 0; i < 4; i++) cyc();
        check("wrap_s0", {28'b0, state}, 32'd0);
        check("wrap_retired", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
